// File: rtl/maze_path_replayer.sv
// Replays a solved maze path from (0,0), checking each step against bounds and the maze memory.
// Latency: 3 cycles per legal move (accept, CHECK, EVAL); out-of-bounds reported 2 cycles after the handshake.
// Backpressure: move_ready only in WAIT_MOVE, so at most one move is in flight; producer holds move until accepted.
module maze_path_replayer #(
  parameter int CW     = 4,
  parameter int GOAL_X = 15,
  parameter int GOAL_Y = 15,
  parameter int SW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          move_valid,
  input  logic [1:0]    move,
  input  logic          move_last,
  output logic          move_ready,
  output logic [CW-1:0] mem_x,
  output logic [CW-1:0] mem_y,
  output logic          mem_rd,
  input  logic          mem_d,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic [SW-1:0] steps,
  output logic          busy,
  output logic          arrived,
  output logic          error,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_MOVE = 3'd1,
    CHECK     = 3'd2,
    EVAL      = 3'd3,
    DONE      = 3'd4,
    ERR       = 3'd5
  } state_t;

  localparam logic [CW-1:0] GX       = CW'(GOAL_X);
  localparam logic [CW-1:0] GY       = CW'(GOAL_Y);
  localparam logic [CW:0]   ONE      = (CW+1)'(1);
  localparam logic [SW-1:0] STEP_MAX = '1;

  state_t      state, state_nx;
  logic [1:0]  mv_q;
  logic        last_q;
  logic [CW:0] cand_x, cand_y;
  logic        oob, at_goal;

  // Candidate at CW+1 bits: the extra bit flags stepping off either edge of the grid.
  always_comb begin
    cand_x = {1'b0, pos_x};
    cand_y = {1'b0, pos_y};
    case (mv_q)
      2'b00:   cand_y = {1'b0, pos_y} - ONE;
      2'b01:   cand_x = {1'b0, pos_x} + ONE;
      2'b10:   cand_x = {1'b0, pos_x} - ONE;
      default: cand_y = {1'b0, pos_y} + ONE;
    endcase
  end

  assign oob     = cand_x[CW] | cand_y[CW];
  assign at_goal = (cand_x[CW-1:0] == GX) && (cand_y[CW-1:0] == GY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nx = WAIT_MOVE;
      WAIT_MOVE:       if (move_valid) state_nx = CHECK;
      CHECK:           state_nx = oob ? ERR : EVAL;
      EVAL: begin
        if (mem_d)       state_nx = ERR;
        else if (last_q) state_nx = at_goal ? DONE : ERR;
        else             state_nx = WAIT_MOVE;
      end
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    move_ready = (state == WAIT_MOVE);
    busy       = (state == WAIT_MOVE) || (state == CHECK) || (state == EVAL);
    arrived    = (state == DONE);
    error      = (state == ERR);
    mem_rd     = (state == CHECK) && !oob;
    mem_x      = pos_x;
    mem_y      = pos_y;
    if (((state == CHECK) && !oob) || (state == EVAL)) begin
      mem_x = cand_x[CW-1:0];
      mem_y = cand_y[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x    <= '0;
      pos_y    <= '0;
      steps    <= '0;
      err_code <= 2'b00;
      mv_q     <= 2'b00;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            pos_x    <= '0;
            pos_y    <= '0;
            steps    <= '0;
            err_code <= 2'b00;
          end
        end
        WAIT_MOVE: begin
          if (move_valid) begin
            mv_q   <= move;
            last_q <= move_last;
          end
        end
        CHECK: begin
          if (oob) err_code <= 2'b10;
        end
        EVAL: begin
          if (mem_d) begin
            err_code <= 2'b01;
          end else begin
            pos_x <= cand_x[CW-1:0];
            pos_y <= cand_y[CW-1:0];
            if (steps != STEP_MAX) steps <= steps + SW'(1);
            if (last_q && !at_goal) err_code <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_replayer.sv
// Directed and randomized replay of maze paths against a grid-walk reference model.
module tb_maze_path_replayer;

  logic       clk = 1'b0;
  logic       rst, start, move_valid, move_last, mem_d;
  logic [1:0] move;
  logic       move_ready, mem_rd, busy, arrived, error;
  logic [3:0] mem_x, mem_y, pos_x, pos_y;
  logic [8:0] steps;
  logic [1:0] err_code;

  maze_path_replayer dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move(move),
    .move_last(move_last), .move_ready(move_ready), .mem_x(mem_x), .mem_y(mem_y),
    .mem_rd(mem_rd), .mem_d(mem_d), .pos_x(pos_x), .pos_y(pos_y), .steps(steps),
    .busy(busy), .arrived(arrived), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  logic walls [0:255];
  always @(posedge clk) if (mem_rd) mem_d <= walls[{mem_y, mem_x}];

  logic cnt_clr;
  int   busy_cyc, rd_cnt;
  always @(posedge clk) begin
    busy_cyc <= cnt_clr ? 0 : busy_cyc + int'(busy);
    rd_cnt   <= cnt_clr ? 0 : rd_cnt + int'(mem_rd);
  end

  int n_cmp = 0, n_err = 0;
  int px, py, ps, merr;
  bit mdone;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_walls();
    for (int i = 0; i < 256; i++) walls[i] = 1'b0;
  endtask

  task automatic model_start();
    px = 0; py = 0; ps = 0; merr = 0; mdone = 0;
  endtask

  // Walk the grid with plain integers: leave the grid, hit a wall, or commit the step.
  task automatic model_step(input logic [1:0] m, input bit l);
    int nx, ny;
    nx = px + ((m == 2'b01) ? 1 : (m == 2'b10) ? -1 : 0);
    ny = py + ((m == 2'b11) ? 1 : (m == 2'b00) ? -1 : 0);
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) merr = 2;
    else if (walls[ny*16 + nx]) merr = 1;
    else begin
      px = nx; py = ny; ps++;
      if (l) begin
        if (px == 15 && py == 15) mdone = 1;
        else merr = 3;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1; cnt_clr = 1'b1;
    @(negedge clk); start = 1'b0; cnt_clr = 1'b0;
  endtask

  // Returns at the negedge after the handshake edge (DUT in CHECK).
  task automatic send(input logic [1:0] m, input bit l, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    n = 0;
    while (!move_ready && n < 20) begin @(negedge clk); n++; end
    if (!move_ready) chk("ready_timeout", int'(move_ready), 1);
    move_valid = 1'b1; move = m; move_last = l;
    @(negedge clk);
    move_valid = 1'b0; move = 2'($urandom); move_last = 1'($urandom);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (busy && !move_ready && n < 10) begin @(negedge clk); n++; end
    if (busy && !move_ready) chk("settle_timeout", int'(busy), 0);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_pos_x"}, int'(pos_x), px);
    chk({tag, "_pos_y"}, int'(pos_y), py);
    chk({tag, "_steps"}, int'(steps), ps);
    chk({tag, "_err_code"}, int'(err_code), merr);
    chk({tag, "_arrived"}, int'(arrived), int'(mdone));
    chk({tag, "_error"}, int'(error), int'(merr != 0));
  endtask

  task automatic mv(input logic [1:0] m, input bit l, input int gap, input string tag);
    send(m, l, gap);
    settle();
    model_step(m, l);
    compare_model(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; move_valid = 1'b0; move = 2'b00; move_last = 1'b0;
    mem_d = 1'b0; cnt_clr = 1'b1;
    clear_walls();
    #2;
    chk("rst_move_ready", int'(move_ready), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({arrived, error}), 0);
    chk("rst_pos", int'({pos_x, pos_y}), 0);
    chk("rst_mem_addr", int'({mem_x, mem_y}), 0);
    chk("rst_steps", int'(steps), 0);
    chk("rst_err_code", int'(err_code), 0);
    @(negedge clk); rst = 1'b0;
    chk("idle_move_ready", int'(move_ready), 0);

    // Open grid, staircase path to the goal at full throughput
    pulse_start(); model_start();
    chk("start_move_ready", int'(move_ready), 1);
    for (int i = 0; i < 15; i++) mv(2'b01, 1'b0, 0, "open_x");
    for (int i = 0; i < 15; i++) mv(2'b11, (i == 14), 0, "open_y");
    chk("open_arrived", int'(arrived), 1);
    chk("open_pos", int'({pos_x, pos_y}), 8'hFF);
    chk("open_steps", int'(steps), 30);
    chk("open_busy_cycles", busy_cyc, 90);

    // Wall directly right of the origin
    walls[1] = 1'b1;
    pulse_start(); model_start();
    send(2'b01, 1'b0, 0);
    chk("wall_mem_rd", int'(mem_rd), 1);
    chk("wall_mem_x", int'(mem_x), 1);
    chk("wall_mem_y", int'(mem_y), 0);
    @(negedge clk);
    chk("wall_eval_error", int'(error), 0);
    @(negedge clk);
    model_step(2'b01, 1'b0);
    compare_model("wall");
    clear_walls();

    // Off the left edge: no memory access, error two cycles after the handshake
    pulse_start(); model_start();
    send(2'b10, 1'b0, 1);
    chk("oob_check_mem_rd", int'(mem_rd), 0);
    chk("oob_check_error", int'(error), 0);
    @(negedge clk);
    model_step(2'b10, 1'b0);
    compare_model("oob");
    chk("oob_rd_count", rd_cnt, 0);

    // Path ends short of the goal
    pulse_start(); model_start();
    mv(2'b01, 1'b0, 2, "short1");
    mv(2'b01, 1'b1, 0, "short2");
    chk("short_err_code", int'(err_code), 3);

    // Backtrack via complemented move, ending off-goal
    pulse_start(); model_start();
    mv(2'b11, 1'b0, 0, "bt1");
    mv(2'b00, 1'b0, 0, "bt2");
    mv(2'b01, 1'b1, 0, "bt3");
    chk("bt_pos_x", int'(pos_x), 1);
    chk("bt_steps", int'(steps), 3);

    // start in ERR restarts with cleared state
    pulse_start(); model_start();
    compare_model("restart");
    chk("restart_move_ready", int'(move_ready), 1);

    // start while busy is ignored
    mv(2'b01, 1'b0, 0, "busy1");
    pulse_start();
    compare_model("busy_start");
    chk("busy_start_ready", int'(move_ready), 1);

    // Reset in EVAL aborts without committing the move
    mv(2'b01, 1'b0, 0, "pre_rst");
    send(2'b11, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstm_busy", int'(busy), 0);
    chk("rstm_move_ready", int'(move_ready), 0);
    chk("rstm_pos", int'({pos_x, pos_y}), 0);
    chk("rstm_steps", int'(steps), 0);
    chk("rstm_flags", int'({arrived, error, mem_rd}), 0);
    chk("rstm_mem_addr", int'({mem_x, mem_y}), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rstm_idle", int'(busy), 0);

    // Random walls and random move sequences with random producer gaps
    for (int ep = 0; ep < 25; ep++) begin
      int len;
      for (int i = 0; i < 256; i++) walls[i] = ($urandom_range(0, 5) == 0);
      len = $urandom_range(1, 40);
      pulse_start(); model_start();
      for (int i = 0; i < len && merr == 0 && !mdone; i++) begin
        logic [1:0] m;
        m = 2'($urandom);
        mv(m, (i == len - 1), $urandom_range(0, 3), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maze_path_replayer.md
# maze_path_replayer

Consumer at the far end of the maze solver's move stream. Accepts solved-path moves one at a time over a valid/ready handshake and replays them from (0,0) on its own position registers. Checks every step against the maze memory read port and the grid bounds. Reports arrival at the goal cell or the first illegal step, so a solved path is independently verified before it drives the display/actuator.

## Interface
Parameters:
- `CW`, 4: coordinate width; grid is 2^CW × 2^CW.
- `GOAL_X`, 15: goal column.
- `GOAL_Y`, 15: goal row.
- `SW`, 9: step counter width.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin replay; sampled only in IDLE, DONE or ERR.
- `move_valid` input 1: `move`/`move_last` are valid.
- `move` input 2: direction code. 00 = y−1, 01 = x+1, 10 = x−1, 11 = y+1. Bitwise complement gives the reverse move.
- `move_last` input 1: this move is the final move of the path.
- `move_ready` output 1: replayer can accept a move.
- `mem_x`, `mem_y` output CW: maze memory read address (candidate cell).
- `mem_rd` output 1: read strobe. The memory has a synchronous read and `mem_d` is valid the cycle after.
- `mem_d` input 1: 1 = wall/blocked cell.
- `pos_x`, `pos_y` output CW: current committed position.
- `steps` output SW: committed move count, saturating at 2^SW−1.
- `busy` output 1: high in WAIT_MOVE, CHECK, EVAL.
- `arrived` output 1: path verified; held in DONE.
- `error` output 1: held in ERR.
- `err_code` output 2: 00 none, 01 wall, 10 out of bounds, 11 path ended off-goal.

## Operation
States: IDLE, WAIT_MOVE, CHECK, EVAL, DONE, ERR.
- **IDLE**: all flags low. On `start`: clear pos, steps, err_code, then go to WAIT_MOVE.
- **WAIT_MOVE**: `move_ready`=1. Handshake when `move_valid`&`move_ready`. On handshake, latch `move` and `move_last`, then go to CHECK. Otherwise stay.
- **CHECK**: compute candidate = pos + delta(move) at CW+1 width.
  - Candidate outside 0..2^CW−1 (x=0 with 10, x=max with 01, y=0 with 00, y=max with 11): `mem_rd`=0, err_code←10, go to ERR.
  - Otherwise: drive `mem_x`/`mem_y` = candidate, `mem_rd`=1, go to EVAL.
- **EVAL**: sample `mem_d`.
  - `mem_d`=1: err_code←01, go to ERR. Position is not updated.
  - `mem_d`=0: pos←candidate, steps←steps+1 (saturating). Then:
    - latched last and candidate = goal: go to DONE.
    - latched last and candidate ≠ goal: err_code←11, go to ERR.
    - not last: return to WAIT_MOVE. Passing through the goal cell mid-path is allowed.
- **DONE**: `arrived`=1. **ERR**: `error`=1. In both, pos, steps and err_code hold. `start` restarts as from IDLE (clear, then WAIT_MOVE).
- `start` is ignored while busy.
- `mem_x`/`mem_y` equal pos when not in CHECK/EVAL.

## Timing
- Reset values: state IDLE; pos (0,0); steps 0; err_code 00. `move_ready`, `mem_rd`, `busy`, `arrived` and `error` are all 0. `mem_x`/`mem_y` are 0.
- Reset mid-replay aborts immediately to IDLE. No partial move commits.
- Each legal move takes 3 cycles: accept, CHECK, EVAL. Maximum throughput is one move per 3 cycles.
- `move_ready` is high only in WAIT_MOVE, so at most one move is in flight. The producer must hold `move`/`move_valid` until the handshake.
- pos/steps update on the clock edge leaving EVAL. `arrived`/`error` assert in the cycle after the deciding EVAL/CHECK.
- Out-of-bounds detection takes 2 cycles after the handshake, with no memory access.
- `start` in the same cycle as reset: reset wins.

## Test plan
- **Open grid, legal path.** All `mem_d`=0. Send 15×01, then 15×11 with `move_last` on the final move. Expect `arrived`=1, pos (15,15), steps 30, err_code 00, 90 busy cycles.
- **Wall hit.** Wall at (1,0); send 01. Expect `mem_rd` with `mem_x`=1, `mem_y`=0. Then `error`=1, err_code 01, pos (0,0), steps 0.
- **Out of bounds.** From (0,0) send 10. Expect `mem_rd` never asserted, err_code 10, `error`=1 two cycles after the handshake.
- **Short path.** Send 01, 01 with last on the second move. Expect err_code 11, pos (2,0), steps 2.
- **Complement/backtrack.** Send 11, then 00, then 01 with last on an open grid. Expect pos (1,0), steps 3. With GOAL_X=1, GOAL_Y=0, expect `arrived`=1.
- **Reset and restart.** Assert `rst` in EVAL mid-path: expect IDLE and all outputs at reset values. Pulse `start` while busy: expect no effect. Pulse `start` in ERR: expect pos (0,0), err_code 00, `move_ready`=1 next cycle.
